// File: rtl/m32632_dram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : m32632_dram_arb
//  Description : DRAM arbiter between the instruction cache (line fills) and
//                the data cache (line fills or single-word writes). It drives
//                one memory beat at a time and hands fill words back to the
//                caches with first/last/strobe write controls.
//                Optional build macro DRAM_ARB_DC_PRIO_EN: the data cache
//                always wins simultaneous requests. When the macro is not
//                defined, simultaneous requests alternate between the caches.
//  Revision    : 1.0 - initial release
// ============================================================================
module m32632_dram_arb #(
    parameter int BURST_LEN = 4
) (
    input  logic        BCLK,
    input  logic        RST,
    input  logic        ENDRAM,
    input  logic        IC_ACC,
    input  logic [27:0] IDRAM_ADR,
    input  logic        DC_ACC,
    input  logic        DC_WR,
    input  logic [27:0] DRAM_ADR,
    input  logic [35:0] DRAM_DI,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [27:0] MEM_A,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_D,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_Q,
    output logic [31:0] DRAM_Q,
    output logic [9:0]  WADDR,
    output logic [2:0]  IWCTRL,
    output logic [2:0]  DWCTRL,
    output logic        IC_MDONE,
    output logic        DC_MDONE
);

    // Width of the word index within one cache line
    localparam int c_IW = $clog2(BURST_LEN);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_IFILL = 3'd1;
    localparam logic [2:0] c_DFILL = 3'd2;
    localparam logic [2:0] c_DWR   = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;

    logic            r_mem_req;
    logic            r_mem_we;
    logic [27:0]     r_mem_a;
    logic [3:0]      r_mem_be;
    logic [31:0]     r_mem_d;
    logic [31:0]     r_dram_q;
    logic [9:0]      r_waddr;
    logic [2:0]      r_iwctrl;
    logic [2:0]      r_dwctrl;
    logic            r_ic_mdone;
    logic            r_dc_mdone;
    logic [c_IW-1:0] r_beat;
    logic            r_last_dc;

    logic            w_mem_req_nxt;
    logic            w_mem_we_nxt;
    logic [27:0]     w_mem_a_nxt;
    logic [3:0]      w_mem_be_nxt;
    logic [31:0]     w_mem_d_nxt;
    logic [31:0]     w_dram_q_nxt;
    logic [9:0]      w_waddr_nxt;
    logic [2:0]      w_iwctrl_nxt;
    logic [2:0]      w_dwctrl_nxt;
    logic            w_ic_mdone_nxt;
    logic            w_dc_mdone_nxt;
    logic [c_IW-1:0] w_beat_nxt;
    logic            w_last_dc_nxt;

    logic            w_pick_dc;
    logic            w_pick_ic;
    logic            w_grant;
    logic            w_ack;
    logic            w_first;
    logic            w_last;
    logic [2:0]      w_ctrl;
    logic [c_IW-1:0] w_idx_inc;
    logic            w_unused_adr_bits;

    // Addresses are word aligned on the memory side; the byte offset is dropped
    assign w_unused_adr_bits = ^{DRAM_ADR[1:0], IDRAM_ADR[1:0]};

`ifdef DRAM_ARB_DC_PRIO_EN
    assign w_pick_dc = DC_ACC;
`else
    // Round-robin: DC wins a tie unless DC was the last side served
    assign w_pick_dc = DC_ACC & (~IC_ACC | ~r_last_dc);
`endif
    assign w_pick_ic = IC_ACC & ~w_pick_dc;
    assign w_grant   = ENDRAM & (w_pick_dc | w_pick_ic);

    // An acknowledge only counts against an outstanding beat
    assign w_ack     = MEM_ACK & r_mem_req;
    assign w_first   = (r_beat == '0);
    assign w_last    = (r_beat == c_IW'(BURST_LEN - 1));
    assign w_ctrl    = {w_last, w_first, 1'b1};
    // Critical-word-first wrap inside the line
    assign w_idx_inc = r_mem_a[c_IW+1:2] + c_IW'(1);

    // State register
    always_ff @(posedge BCLK) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a started operation always runs to completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant) begin
                    if (w_pick_dc) begin
                        w_state_nxt = DC_WR ? c_DWR : c_DFILL;
                    end else begin
                        w_state_nxt = c_IFILL;
                    end
                end
            end
            // Request drops after the last beat; one cycle later report done
            c_IFILL, c_DFILL: begin
                if (!r_mem_req) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DWR: begin
                if (w_ack) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output/datapath next values: grant capture, beat sequencing, fill return
    always_comb begin
        w_mem_req_nxt  = r_mem_req;
        w_mem_we_nxt   = r_mem_we;
        w_mem_a_nxt    = r_mem_a;
        w_mem_be_nxt   = r_mem_be;
        w_mem_d_nxt    = r_mem_d;
        w_dram_q_nxt   = r_dram_q;
        w_waddr_nxt    = r_waddr;
        w_iwctrl_nxt   = 3'b000;
        w_dwctrl_nxt   = 3'b000;
        w_ic_mdone_nxt = 1'b0;
        w_dc_mdone_nxt = 1'b0;
        w_beat_nxt     = r_beat;
        w_last_dc_nxt  = r_last_dc;
        case (r_state)
            c_IDLE: begin
                if (w_grant) begin
                    w_mem_req_nxt = 1'b1;
                    w_beat_nxt    = '0;
                    w_last_dc_nxt = w_pick_dc;
                    if (w_pick_dc) begin
                        w_mem_a_nxt  = {DRAM_ADR[27:2], 2'b00};
                        w_mem_we_nxt = DC_WR;
                        w_mem_be_nxt = DC_WR ? DRAM_DI[35:32] : 4'hF;
                        w_mem_d_nxt  = DC_WR ? DRAM_DI[31:0] : 32'h0;
                    end else begin
                        w_mem_a_nxt  = {IDRAM_ADR[27:2], 2'b00};
                        w_mem_we_nxt = 1'b0;
                        w_mem_be_nxt = 4'hF;
                        w_mem_d_nxt  = 32'h0;
                    end
                end
            end
            c_IFILL, c_DFILL: begin
                if (w_ack) begin
                    w_dram_q_nxt = MEM_Q;
                    w_waddr_nxt  = r_mem_a[11:2];
                    if (r_state == c_IFILL) begin
                        w_iwctrl_nxt = w_ctrl;
                    end else begin
                        w_dwctrl_nxt = w_ctrl;
                    end
                    w_beat_nxt              = r_beat + c_IW'(1);
                    w_mem_a_nxt[c_IW+1:2]   = w_idx_inc;
                    if (w_last) begin
                        w_mem_req_nxt = 1'b0;
                    end
                end else if (!r_mem_req) begin
                    w_ic_mdone_nxt = (r_state == c_IFILL);
                    w_dc_mdone_nxt = (r_state == c_DFILL);
                end
            end
            c_DWR: begin
                if (w_ack) begin
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_dc_mdone_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs; reset abandons any outstanding beat
    always_ff @(posedge BCLK) begin
        if (RST) begin
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_a    <= 28'h0;
            r_mem_be   <= 4'h0;
            r_mem_d    <= 32'h0;
            r_dram_q   <= 32'h0;
            r_waddr    <= 10'h0;
            r_iwctrl   <= 3'b000;
            r_dwctrl   <= 3'b000;
            r_ic_mdone <= 1'b0;
            r_dc_mdone <= 1'b0;
            r_beat     <= '0;
            r_last_dc  <= 1'b0;
        end else begin
            r_mem_req  <= w_mem_req_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_mem_a    <= w_mem_a_nxt;
            r_mem_be   <= w_mem_be_nxt;
            r_mem_d    <= w_mem_d_nxt;
            r_dram_q   <= w_dram_q_nxt;
            r_waddr    <= w_waddr_nxt;
            r_iwctrl   <= w_iwctrl_nxt;
            r_dwctrl   <= w_dwctrl_nxt;
            r_ic_mdone <= w_ic_mdone_nxt;
            r_dc_mdone <= w_dc_mdone_nxt;
            r_beat     <= w_beat_nxt;
            r_last_dc  <= w_last_dc_nxt;
        end
    end

    assign MEM_REQ  = r_mem_req;
    assign MEM_WE   = r_mem_we;
    assign MEM_A    = r_mem_a;
    assign MEM_BE   = r_mem_be;
    assign MEM_D    = r_mem_d;
    assign DRAM_Q   = r_dram_q;
    assign WADDR    = r_waddr;
    assign IWCTRL   = r_iwctrl;
    assign DWCTRL   = r_dwctrl;
    assign IC_MDONE = r_ic_mdone;
    assign DC_MDONE = r_dc_mdone;

endmodule
`default_nettype wire

// File: tb/tb_m32632_dram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m32632_dram_arb
//  Description : Scoreboard bench for m32632_dram_arb. Stimulus pushes the
//                expected memory beats, cache writes and done pulses; a
//                monitor pops and compares them as the DUT presents them.
//                Memory read data is {4'hC, beat address}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m32632_dram_arb;

    logic        BCLK;
    logic        RST;
    logic        ENDRAM;
    logic        IC_ACC;
    logic [27:0] IDRAM_ADR;
    logic        DC_ACC;
    logic        DC_WR;
    logic [27:0] DRAM_ADR;
    logic [35:0] DRAM_DI;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [27:0] MEM_A;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_D;
    logic        MEM_ACK;
    logic [31:0] MEM_Q;
    logic [31:0] DRAM_Q;
    logic [9:0]  WADDR;
    logic [2:0]  IWCTRL;
    logic [2:0]  DWCTRL;
    logic        IC_MDONE;
    logic        DC_MDONE;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_delay = 0;
    logic force_ack = 1'b0;

    logic [127:0] beat_q[$];
    logic [127:0] wr_q[$];
    logic [127:0] done_q[$];

    m32632_dram_arb #(.BURST_LEN(4)) dut (
        .BCLK(BCLK), .RST(RST), .ENDRAM(ENDRAM),
        .IC_ACC(IC_ACC), .IDRAM_ADR(IDRAM_ADR),
        .DC_ACC(DC_ACC), .DC_WR(DC_WR), .DRAM_ADR(DRAM_ADR), .DRAM_DI(DRAM_DI),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_BE(MEM_BE),
        .MEM_D(MEM_D), .MEM_ACK(MEM_ACK), .MEM_Q(MEM_Q),
        .DRAM_Q(DRAM_Q), .WADDR(WADDR), .IWCTRL(IWCTRL), .DWCTRL(DWCTRL),
        .IC_MDONE(IC_MDONE), .DC_MDONE(DC_MDONE)
    );

    initial begin
        BCLK = 1'b0;
        forever #5 BCLK = ~BCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    function automatic logic [127:0] beat_vec();
        return 128'({MEM_WE, MEM_A, MEM_BE, MEM_D});
    endfunction

    function automatic logic [127:0] all_outs();
        return 128'({MEM_REQ, MEM_WE, MEM_A, MEM_BE, MEM_D, DRAM_Q, WADDR,
                     IWCTRL, DWCTRL, IC_MDONE, DC_MDONE});
    endfunction

    // side: 0 = IC, 1 = DC
    task automatic push_fill(input logic side, input logic [27:0] a0, input logic [27:0] a1,
                             input logic [27:0] a2, input logic [27:0] a3,
                             input int nb, input bit with_done);
        logic [27:0] a[4];
        logic [2:0]  ctrl;
        a = '{a0, a1, a2, a3};
        for (int i = 0; i < nb; i++) begin
            ctrl = (i == 0) ? 3'b011 : ((i == 3) ? 3'b101 : 3'b001);
            beat_q.push_back(128'({1'b0, a[i], 4'hF, 32'h0}));
            wr_q.push_back(128'({side ? 3'b000 : ctrl, side ? ctrl : 3'b000,
                                 a[i][11:2], 4'hC, a[i]}));
        end
        if (with_done) done_q.push_back(side ? 128'(2'b01) : 128'(2'b10));
    endtask

    task automatic push_write(input logic [27:0] a, input logic [3:0] be, input logic [31:0] d);
        beat_q.push_back(128'({1'b1, a, be, d}));
        done_q.push_back(128'(2'b01));
    endtask

    task automatic tick();
        @(posedge BCLK);
        #1;
    endtask

    task automatic wait_done(output int side);
        side = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge BCLK);
            if (IC_MDONE) begin side = 0; break; end
            if (DC_MDONE) begin side = 1; break; end
        end
        if (side < 0) unexpected("wait_done_timeout", 128'(0));
    endtask

    task automatic drop(input int side);
        tick();
        if (side == 0) IC_ACC = 1'b0;
        else DC_ACC = 1'b0;
    endtask

    // Memory responder: acknowledges after ack_delay waiting cycles
    initial begin
        int cnt;
        cnt = 0;
        MEM_ACK = 1'b0;
        MEM_Q = 32'h0;
        forever begin
            @(posedge BCLK);
            #1;
            if (MEM_REQ && cnt >= ack_delay) begin
                MEM_ACK = 1'b1;
                MEM_Q = {4'hC, MEM_A};
                cnt = 0;
            end else begin
                MEM_ACK = force_ack;
                if (MEM_REQ) cnt++;
                else cnt = 0;
            end
        end
    end

    // Monitor: compares every presented beat, cache write and done pulse
    initial begin
        logic [127:0] prev_vec;
        logic prev_req, prev_ack, prev_rst;
        prev_vec = '0; prev_req = 1'b0; prev_ack = 1'b0; prev_rst = 1'b1;
        forever begin
            @(negedge BCLK);
            if (!RST) begin
                if (MEM_REQ && prev_req && !prev_ack && !prev_rst)
                    check("mem_stable", beat_vec(), prev_vec);
                if (MEM_REQ && MEM_ACK) begin
                    if (beat_q.size() == 0) unexpected("beat", beat_vec());
                    else check("beat", beat_vec(), beat_q.pop_front());
                end
            end
            if (IWCTRL != 3'b000 || DWCTRL != 3'b000) begin
                if (wr_q.size() == 0)
                    unexpected("cache_wr", 128'({IWCTRL, DWCTRL, WADDR, DRAM_Q}));
                else
                    check("cache_wr", 128'({IWCTRL, DWCTRL, WADDR, DRAM_Q}), wr_q.pop_front());
            end
            if (IC_MDONE || DC_MDONE) begin
                if (done_q.size() == 0) unexpected("mdone", 128'({IC_MDONE, DC_MDONE}));
                else check("mdone", 128'({IC_MDONE, DC_MDONE}), done_q.pop_front());
            end
            prev_req = MEM_REQ;
            prev_ack = MEM_ACK;
            prev_rst = RST;
            prev_vec = beat_vec();
        end
    end

    // Directed stimulus
    initial begin
        int s1, s2, s3, cnt;
        RST = 1'b1; ENDRAM = 1'b0; IC_ACC = 1'b0; IDRAM_ADR = '0;
        DC_ACC = 1'b0; DC_WR = 1'b0; DRAM_ADR = '0; DRAM_DI = '0;
        repeat (3) tick();
        @(negedge BCLK);
        check("reset_outputs", all_outs(), 128'(0));
        tick();
        RST = 1'b0;
        ENDRAM = 1'b1;
        tick();

        // Simultaneous requests after reset: DC first
`ifdef DRAM_ARB_DC_PRIO_EN
        push_fill(1'b1, 28'h100, 28'h104, 28'h108, 28'h10C, 4, 1'b1);
        push_fill(1'b1, 28'h100, 28'h104, 28'h108, 28'h10C, 4, 1'b1);
        push_fill(1'b0, 28'h20C, 28'h200, 28'h204, 28'h208, 4, 1'b1);
`else
        push_fill(1'b1, 28'h100, 28'h104, 28'h108, 28'h10C, 4, 1'b1);
        push_fill(1'b0, 28'h20C, 28'h200, 28'h204, 28'h208, 4, 1'b1);
        push_fill(1'b1, 28'h100, 28'h104, 28'h108, 28'h10C, 4, 1'b1);
`endif
        DRAM_ADR = 28'h100; DC_WR = 1'b0; IDRAM_ADR = 28'h20E;
        DC_ACC = 1'b1; IC_ACC = 1'b1;
        wait_done(s1);
        check("first_grant_side", 128'(s1), 128'(1));
        wait_done(s2);
`ifdef DRAM_ARB_DC_PRIO_EN
        check("second_grant_side", 128'(s2), 128'(1));
`else
        check("second_grant_side", 128'(s2), 128'(0));
`endif
        drop(s2);
        wait_done(s3);
        check("third_grant_side", 128'(s3), 128'(1 - s2));
        drop(s3);
        repeat (2) tick();

        // I-fill critical word first from 0x48
        push_fill(1'b0, 28'h48, 28'h4C, 28'h40, 28'h44, 4, 1'b1);
        IDRAM_ADR = 28'h48; IC_ACC = 1'b1;
        wait_done(s1);
        drop(s1);
        repeat (2) tick();

        // Write with delayed ACK: held 4 cycles, done one cycle after ACK
        push_write(28'h330, 4'h5, 32'hDEADBEEF);
        ack_delay = 3;
        DRAM_ADR = 28'h332; DC_WR = 1'b1; DRAM_DI = 36'h5_DEADBEEF; DC_ACC = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge BCLK);
            if (MEM_REQ) cnt++;
            if (MEM_REQ && MEM_ACK) break;
        end
        check("write_hold_cycles", 128'(cnt), 128'(4));
        @(negedge BCLK);
        check("write_done_timing", 128'(DC_MDONE), 128'(1));
        drop(1);
        ack_delay = 0;
        repeat (2) tick();

        // Zero byte-enable write still performs a beat
        push_write(28'h44, 4'h0, 32'h12345678);
        DRAM_ADR = 28'h44; DRAM_DI = 36'h0_12345678; DC_ACC = 1'b1;
        wait_done(s1);
        drop(s1);
        DC_WR = 1'b0;
        repeat (2) tick();

        // ENDRAM low blocks grants; grant follows raising it
        push_fill(1'b0, 28'h10, 28'h14, 28'h18, 28'h1C, 4, 1'b1);
        ENDRAM = 1'b0; IDRAM_ADR = 28'h10; IC_ACC = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge BCLK);
            if (MEM_REQ) cnt++;
        end
        check("endram_blocks", 128'(cnt), 128'(0));
        tick();
        ENDRAM = 1'b1;
        @(negedge BCLK);
        check("no_grant_yet", 128'(MEM_REQ), 128'(0));
        @(negedge BCLK);
        check("grant_after_endram", 128'(MEM_REQ), 128'(1));
        // Withdrawing enable and request mid-burst must not abort it
        tick();
        ENDRAM = 1'b0; IC_ACC = 1'b0;
        wait_done(s1);
        check("burst_completes", 128'(s1), 128'(0));
        ENDRAM = 1'b1;
        repeat (2) tick();

        // Stray ACK while idle is ignored
        force_ack = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge BCLK);
            if (MEM_REQ || IWCTRL != 3'b000 || DWCTRL != 3'b000) cnt++;
        end
        check("stray_ack_ignored", 128'(cnt), 128'(0));
        tick();
        force_ack = 1'b0;
        repeat (2) tick();

        // Reset after the second fill beat abandons the burst
        push_fill(1'b0, 28'h80, 28'h84, 28'h88, 28'h8C, 2, 1'b0);
        IDRAM_ADR = 28'h80; IC_ACC = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge BCLK);
            if (MEM_REQ && MEM_ACK) cnt++;
            if (cnt == 2) break;
        end
        tick();
        RST = 1'b1; IC_ACC = 1'b0;
        tick();
        RST = 1'b0;
        @(negedge BCLK);
        check("reset_mid_burst", all_outs(), 128'(0));
        repeat (4) tick();

        // Normal grant after the reset
        push_fill(1'b0, 28'h88, 28'h8C, 28'h80, 28'h84, 4, 1'b1);
        IDRAM_ADR = 28'h88; IC_ACC = 1'b1;
        wait_done(s1);
        drop(s1);
        repeat (3) tick();

        check("beat_queue_empty", 128'(beat_q.size()), 128'(0));
        check("wr_queue_empty", 128'(wr_q.size()), 128'(0));
        check("done_queue_empty", 128'(done_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m32632_dram_arb.md
M32632_DRAM_ARB -- requirements
Module: m32632_dram_arb

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, meaning words per cache-line fill (legal values 2, 4, 8).
REQ-002 The block SHALL have port BCLK, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port ENDRAM, input, 1, memory enable; when low, no new grant is issued.
REQ-005 The block SHALL have port IC_ACC, input, 1, instruction-cache fill request, held until IC_MDONE.
REQ-006 The block SHALL have port IDRAM_ADR, input, 28, instruction fill byte address.
REQ-007 The block SHALL have port DC_ACC, input, 1, data-cache request, held until DC_MDONE.
REQ-008 The block SHALL have port DC_WR, input, 1, qualifies DC_ACC: 1 = single-word write, 0 = line fill.
REQ-009 The block SHALL have port DRAM_ADR, input, 28, data-side byte address.
REQ-010 The block SHALL have port DRAM_DI, input, 36, write data: [35:32] byte enables, [31:0] data.
REQ-011 The block SHALL have port MEM_REQ, output, 1, memory beat request.
REQ-012 The block SHALL have port MEM_WE, output, 1, memory write enable.
REQ-013 The block SHALL have port MEM_A, output, 28, memory byte address with [1:0]=0.
REQ-014 The block SHALL have port MEM_BE, output, 4, memory byte enables.
REQ-015 The block SHALL have port MEM_D, output, 32, memory write data.
REQ-016 The block SHALL have port MEM_ACK, input, 1, beat accepted/completed when sampled high with MEM_REQ high.
REQ-017 The block SHALL have port MEM_Q, input, 32, read data valid with MEM_ACK.
REQ-018 The block SHALL have port DRAM_Q, output, 32, registered fill word to the caches.
REQ-019 The block SHALL have port WADDR, output, 10, cache word address [11:2] of DRAM_Q.
REQ-020 The block SHALL have port IWCTRL, output, 3, I-cache write control {last, first, strobe}.
REQ-021 The block SHALL have port DWCTRL, output, 3, D-cache write control {last, first, strobe}.
REQ-022 The block SHALL have port IC_MDONE, output, 1, one-cycle I-side completion pulse.
REQ-023 The block SHALL have port DC_MDONE, output, 1, one-cycle D-side completion pulse.

Function
REQ-024 The FSM SHALL have the states IDLE, IFILL, DFILL, DWR and DONE.
REQ-025 In IDLE with ENDRAM=1, the block SHALL grant a single requester directly; when both request, it SHALL alternate on a last-served flag, with DC served first after reset.
REQ-026 At grant, the block SHALL register the address and DRAM_DI, enter IFILL, DFILL (DC_WR=0) or DWR (DC_WR=1), and assert MEM_REQ on the next cycle.
REQ-027 MEM_REQ, MEM_A, MEM_WE, MEM_BE and MEM_D SHALL remain stable until MEM_ACK is sampled high; each ACK SHALL consume exactly one beat; an ACK while MEM_REQ=0 SHALL be ignored.
REQ-028 A fill SHALL issue BURST_LEN reads (MEM_WE=0, MEM_BE=4'hF), critical word first, with the word index starting at the address index bits and incrementing modulo BURST_LEN within the line.
REQ-029 On each fill ACK, the block SHALL register DRAM_Q<=MEM_Q, WADDR to the beat's word address, and the granted side's xWCTRL to {last beat, first beat, 1} for exactly one cycle; the other side's xWCTRL SHALL be 0.
REQ-030 When MEM_ACK is sampled for the last beat, MEM_REQ SHALL deassert on that same edge without a gap-free overrun.
REQ-031 DWR SHALL issue one write with MEM_WE=1, MEM_BE=DRAM_DI[35:32] and MEM_D=DRAM_DI[31:0]; BE=0 SHALL still perform the beat.
REQ-032 The xMDONE pulse SHALL occur one cycle after the last write strobe (fill) or one cycle after ACK (write); the FSM SHALL then pass through DONE for one cycle, ignoring both ACC inputs, and return to IDLE.
REQ-033 Deassertion of ENDRAM or ACC mid-operation SHALL NOT abort the operation; the burst SHALL complete and pulse MDONE.

Reset
REQ-034 RST SHALL place the FSM in IDLE, set the last-served flag to IC, and drive all outputs to 0 on the next edge, including mid-burst, where the outstanding beat is abandoned.

Configuration
REQ-035 With DRAM_ARB_DC_PRIO_EN defined, DC SHALL always win simultaneous requests; without the macro, the round-robin of REQ-025 SHALL apply.

Verification
REQ-036 Test: IC_ACC with IDRAM_ADR=0x0000048 and ACK every cycle -> MEM_A 0x48, 0x4C, 0x40, 0x44; IWCTRL 011, 001, 001, 101; IC_MDONE pulses once.
REQ-037 Test: IC_ACC and DC_ACC raised together after reset -> DC served first, then IC; with DRAM_ARB_DC_PRIO_EN defined and DC re-requesting, DC is served twice.
REQ-038 Test: DC write with DRAM_DI=0x5_DEADBEEF and ACK delayed 3 cycles -> MEM_WE=1, MEM_BE=0x5, MEM_D=0xDEADBEEF held stable for 4 cycles; DC_MDONE pulses one cycle after ACK.
REQ-039 Test: ENDRAM=0 with IC_ACC=1 -> MEM_REQ stays 0; raise ENDRAM -> grant occurs on the next cycle.
REQ-040 Test: RST asserted after the second fill beat -> all outputs are 0 next cycle and no MDONE pulses; a new request is granted normally afterwards.
